// File: rtl/control_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM state
// codes, ALU commands, condition codes and datapath select values.
package control_pkg;

  // Controller states; the 4-bit code is also exported on the State port
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8
  } state_t;

  // Instruction class (Instruction[27:26])
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // ALU commands
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;

  // Condition codes that can evaluate true
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_AL = 4'b1110;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_SHIFT = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_FOUR  = 2'd2;
  localparam logic [1:0] SRCB_REGB  = 2'd3;

  // ResultSrc selects
  localparam logic [1:0] RES_ALUOUT = 2'd0;
  localparam logic [1:0] RES_DATA   = 2'd1;
  localparam logic [1:0] RES_ALU    = 2'd2;

  // ImmSrc selects
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

endpackage

// File: rtl/cond_check.sv
// Condition-field evaluator: decides whether the current instruction
// executes given the stored Z flag. Unsupported codes never execute.
module cond_check
  import control_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic       Z_FLAG,
  output logic       CondEx
);

  // Map condition code to an execute/skip decision
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = Z_FLAG;
      COND_NE: CondEx = ~Z_FLAG;
      COND_AL: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle controller: sequences FETCH/DECODE and the per-class states,
// latches the condition result when leaving DECODE and decodes every
// datapath select/enable combinationally from the current state.
module multicycle_control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       Z_FLAG,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic       Write_Z_ENABLE,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [3:0] ALUControl,
  output logic [3:0] State
);

  state_t state_q, state_d;
  logic   condex_q, condex_d;
  logic   cond_ex;

  // Rd and the I bit do not influence sequencing; kept as ports for the datapath
  logic unused_fields;
  assign unused_fields = ^{Rd, Funct[5]};

  cond_check u_cond_check (
    .Cond   (Cond),
    .Z_FLAG (Z_FLAG),
    .CondEx (cond_ex)
  );

  assign State = state_q;

  // State and condition registers; reset abandons the instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      condex_q <= condex_d;
    end
  end

  // Next-state logic; condition result is captured only on leaving DECODE
  always_comb begin
    state_d  = state_q;
    condex_d = (state_q == S_DECODE) ? cond_ex : condex_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_DP:   state_d = S_EXECUTE;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; anything not driven for a state stays 0
  always_comb begin
    PCWrite        = 1'b0;
    MemWrite       = 1'b0;
    RegWrite       = 1'b0;
    IRWrite        = 1'b0;
    AdrSrc         = 1'b0;
    ALUSrcA        = 1'b0;
    Write_Z_ENABLE = 1'b0;
    ALUSrcB        = 2'd0;
    ResultSrc      = 2'd0;
    ImmSrc         = 2'd0;
    RegSrc         = 2'd0;
    ALUControl     = 4'd0;
    case (state_q)
      S_FETCH: begin
        IRWrite    = 1'b1;
        PCWrite    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALU;
        ALUControl = ALU_ADD;
      end
      S_DECODE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALU;
        RegSrc     = {Op == OP_MEM, Op == OP_BR};
        ALUControl = ALU_ADD;
      end
      S_EXECUTE: begin
        ALUSrcB        = SRCB_SHIFT;
        ALUControl     = Funct[4:1];
        Write_Z_ENABLE = Funct[0] & condex_q;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = condex_q & (Funct[4:1] != ALU_CMP);
      end
      S_MEMADR: begin
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_12;
        RegSrc     = 2'b10;
        ALUControl = ALU_ADD;
      end
      S_MEMREAD: begin
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = condex_q;
      end
      S_MEMWRITE: begin
        ResultSrc = RES_ALUOUT;
        AdrSrc    = 1'b1;
        MemWrite  = condex_q;
      end
      S_BRANCH: begin
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = IMM_24;
        ResultSrc  = RES_ALU;
        ALUControl = ALU_ADD;
        PCWrite    = condex_q;
        RegWrite   = condex_q & Funct[4];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: an instruction-level model predicts the
// state sequence and every output per cycle; a compare process checks each
// cycle, and literal checks on captured snapshots pin the model.
module tb_multicycle_control_unit;
  import control_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, memw, regw, irw, adr, srca, wze;
    logic [1:0] srcb, res, imm, rsrc;
    logic [3:0] aluc;
  } outs_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       Z_FLAG;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, Write_Z_ENABLE;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [3:0] ALUControl, State;

  multicycle_control_unit dut (
    .clk            (clk),
    .reset          (reset),
    .Cond           (Cond),
    .Op             (Op),
    .Funct          (Funct),
    .Rd             (Rd),
    .Z_FLAG         (Z_FLAG),
    .PCWrite        (PCWrite),
    .MemWrite       (MemWrite),
    .RegWrite       (RegWrite),
    .IRWrite        (IRWrite),
    .AdrSrc         (AdrSrc),
    .ALUSrcA        (ALUSrcA),
    .Write_Z_ENABLE (Write_Z_ENABLE),
    .ALUSrcB        (ALUSrcB),
    .ResultSrc      (ResultSrc),
    .ImmSrc         (ImmSrc),
    .RegSrc         (RegSrc),
    .ALUControl     (ALUControl),
    .State          (State)
  );

  always #5 clk = ~clk;

  outs_t dut_o;
  assign dut_o = {State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                  Write_Z_ENABLE, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

  int    n_cmp  = 0;
  int    n_fail = 0;
  outs_t exp_o;
  logic  exp_valid = 1'b0;
  logic  m_condex  = 1'b0;
  outs_t snap [0:7];
  int    nstates;

  // Does the instruction execute, given its condition and the Z flag
  function automatic logic cond_holds(logic [3:0] c, logic z);
    if (c == 4'b0000) return z;
    if (c == 4'b0001) return !z;
    if (c == 4'b1110) return 1'b1;
    return 1'b0;
  endfunction

  // Expected control word for one state of an instruction
  function automatic outs_t model(state_t s, logic [1:0] op, logic [5:0] f, logic cx);
    outs_t o;
    o    = '0;
    o.st = s;
    case (s)
      S_FETCH:    begin o.irw = 1; o.pcw = 1; o.srca = 1; o.srcb = 2; o.res = 2; o.aluc = 4'b0100; end
      S_DECODE:   begin o.srca = 1; o.srcb = 2; o.res = 2; o.aluc = 4'b0100;
                        o.rsrc = {op == 2'b01, op == 2'b10}; end
      S_EXECUTE:  begin o.aluc = f[4:1]; o.wze = f[0] & cx; end
      S_ALUWB:    begin o.regw = cx && (f[4:1] != 4'b1010); end
      S_MEMADR:   begin o.srcb = 1; o.imm = 2'b01; o.rsrc = 2'b10; o.aluc = 4'b0100; end
      S_MEMREAD:  begin o.adr = 1; end
      S_MEMWB:    begin o.res = 1; o.regw = cx; end
      S_MEMWRITE: begin o.adr = 1; o.memw = cx; end
      S_BRANCH:   begin o.srcb = 1; o.imm = 2'b10; o.res = 2; o.aluc = 4'b0100;
                        o.pcw = cx; o.regw = cx & f[4]; end
      default: ;
    endcase
    return o;
  endfunction

  // Per-cycle comparison of the whole control word
  always @(negedge clk) begin
    if (exp_valid) begin
      n_cmp++;
      if (dut_o !== exp_o) begin
        n_fail++;
        $display("FAIL cycle t=%0t: got %h required %h", $time, dut_o, exp_o);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Run one instruction from FETCH; optionally assert reset in abort_at
  task automatic run(string name, logic [3:0] c, logic [1:0] op, logic [5:0] f,
                     logic zdec, logic zexe, logic do_abort, state_t abort_at);
    state_t seq[$];
    Cond = c; Op = op; Funct = f; Rd = 4'd3; Z_FLAG = zdec;
    seq = '{S_FETCH, S_DECODE};
    case (op)
      2'b00: begin seq.push_back(S_EXECUTE); seq.push_back(S_ALUWB); end
      2'b01: begin
        seq.push_back(S_MEMADR);
        if (f[0]) begin seq.push_back(S_MEMREAD); seq.push_back(S_MEMWB); end
        else seq.push_back(S_MEMWRITE);
      end
      2'b10: seq.push_back(S_BRANCH);
      default: ;
    endcase
    if (do_abort) begin
      for (int i = 0; i < seq.size(); i++)
        if (seq[i] == abort_at) begin
          while (seq.size() > i + 1) void'(seq.pop_back());
          break;
        end
    end
    for (int i = 0; i < seq.size(); i++) begin
      exp_o     = model(seq[i], op, f, m_condex);
      exp_valid = 1'b1;
      @(negedge clk);
      snap[i] = dut_o;
      #1;
      if (seq[i] == S_DECODE) m_condex = cond_holds(c, Z_FLAG);
      if (seq[i] == S_EXECUTE) Z_FLAG = zexe;
      if (do_abort && seq[i] == abort_at) begin reset = 1'b1; m_condex = 1'b0; end
      @(posedge clk); #1;
    end
    reset   = 1'b0;
    nstates = seq.size();
    $display("instr %s cond=%b op=%b funct=%b states=%0d", name, c, op, f, nstates);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Cond = 4'd0; Op = 2'd0; Funct = 6'd0; Rd = 4'd0; Z_FLAG = 1'b0;
    @(posedge clk); #1;
    exp_o = model(S_FETCH, 2'b00, 6'd0, 1'b0);
    exp_valid = 1'b1;
    @(negedge clk);
    chk("reset_state", 32'(State), 32'd0);
    chk("reset_irwrite", 32'(IRWrite), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;

    run("ADD", 4'b1110, 2'b00, 6'b001000, 1'b0, 1'b0, 1'b0, S_FETCH);
    chk("add_nstates", 32'(nstates), 32'd4);
    chk("add_fetch_pcw", 32'(snap[0].pcw), 32'd1);
    chk("add_exec_aluc", 32'(snap[2].aluc), 32'b0100);
    chk("add_exec_wze", 32'(snap[2].wze), 32'd0);
    chk("add_wb_regw", 32'(snap[3].regw), 32'd1);

    run("CMPS", 4'b1110, 2'b00, 6'b010101, 1'b0, 1'b1, 1'b0, S_FETCH);
    chk("cmp_exec_wze", 32'(snap[2].wze), 32'd1);
    chk("cmp_wb_regw", 32'(snap[3].regw), 32'd0);

    run("SUBSEQ_z1", 4'b0000, 2'b00, 6'b000101, 1'b1, 1'b0, 1'b0, S_FETCH);
    chk("subseq1_wb_regw", 32'(snap[3].regw), 32'd1);

    run("SUBSEQ_z0", 4'b0000, 2'b00, 6'b000101, 1'b0, 1'b0, 1'b0, S_FETCH);
    chk("subseq0_wze", 32'(snap[2].wze), 32'd0);
    chk("subseq0_wb_regw", 32'(snap[3].regw), 32'd0);

    run("LDR", 4'b1110, 2'b01, 6'b011001, 1'b0, 1'b0, 1'b0, S_FETCH);
    chk("ldr_nstates", 32'(nstates), 32'd5);
    chk("ldr_memadr_imm", 32'(snap[2].imm), 32'b01);
    chk("ldr_memread_adr", 32'(snap[3].adr), 32'd1);
    chk("ldr_memwb", 32'({snap[4].res, snap[4].regw}), 32'b011);

    run("STR", 4'b1110, 2'b01, 6'b011000, 1'b0, 1'b0, 1'b0, S_FETCH);
    chk("str_memwrite", 32'(snap[3].memw), 32'd1);
    chk("str_decode_rsrc", 32'(snap[1].rsrc), 32'b10);
    chk("str_memadr_rsrc", 32'(snap[2].rsrc), 32'b10);

    run("BL", 4'b1110, 2'b10, 6'b110000, 1'b0, 1'b0, 1'b0, S_FETCH);
    chk("bl_nstates", 32'(nstates), 32'd3);
    chk("bl_branch", 32'({snap[2].pcw, snap[2].regw}), 32'b11);

    run("BNE_z1", 4'b0001, 2'b10, 6'b100000, 1'b1, 1'b1, 1'b0, S_FETCH);
    chk("bne_branch", 32'({snap[2].pcw, snap[2].regw}), 32'b00);

    run("UNDEF", 4'b1110, 2'b11, 6'b000000, 1'b0, 1'b0, 1'b0, S_FETCH);
    chk("undef_nstates", 32'(nstates), 32'd2);

    run("LDR_abort", 4'b1110, 2'b01, 6'b011001, 1'b0, 1'b0, 1'b1, S_MEMREAD);
    chk("abort_state", 32'(State), 32'd0);
    chk("abort_nowrite", 32'({snap[3].memw, snap[3].regw}), 32'd0);

    run("ADD_after", 4'b1110, 2'b00, 6'b001000, 1'b0, 1'b0, 1'b0, S_FETCH);
    chk("add_after_wb", 32'(snap[3].regw), 32'd1);

    exp_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
